// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NREQ requesters with a valid/ready tagged response
// Ports: CLK100MHZ/rst (async, active high); req_valid/req_a/req_b/req_s in, req_ready out (one-hot grant);
//        alu_a/alu_b/alu_s registered ALU operands, alu_r/alu_c/alu_v ALU results;
//        rsp_valid/rsp_ready handshake with rsp_id/rsp_r/rsp_c/rsp_v captured result; busy = not idle.
module alu_arbiter #(
    parameter int NREQ        = 2,
    parameter int W           = 8,
    parameter int SW          = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              CLK100MHZ,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*SW-1:0] req_s,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [SW-1:0]     alu_s,
    input  logic [W-1:0]      alu_r,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_c,
    output logic              rsp_v,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [3:0]    cnt_q;
    logic [W-1:0]  alu_a_q, alu_b_q, rsp_r_q;
    logic [SW-1:0] alu_s_q;
    logic [1:0]    rsp_id_q;
    logic          rsp_valid_q, rsp_c_q, rsp_v_q;
    // requesters padded to four so the winner index is always a clean 2-bit select
    logic [3:0]    val4;
    logic [W-1:0]  a4 [4];
    logic [W-1:0]  b4 [4];
    logic [SW-1:0] s4 [4];
    logic [2:0]    idx;
    logic [1:0]    win;
    logic          found;
    for (genvar i = 0; i < 4; i++) begin : g_pad
        if (i < NREQ) begin : g_on
            assign val4[i] = req_valid[i];
            assign a4[i]   = req_a[i*W +: W];
            assign b4[i]   = req_b[i*W +: W];
            assign s4[i]   = req_s[i*SW +: SW];
        end else begin : g_off
            assign val4[i] = 1'b0;
            assign a4[i]   = '0;
            assign b4[i]   = '0;
            assign s4[i]   = '0;
        end
    end
    // scan from the far end back to ptr so the last hit is the first valid at or after ptr
    always_comb begin
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + 3'(k);
            idx = (idx >= 3'(NREQ)) ? idx - 3'(NREQ) : idx;
            if (val4[idx[1:0]]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = !rst && state_q == IDLE && found && win == 2'(i);
    end
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_ready) begin
                    alu_a_q  <= a4[win];
                    alu_b_q  <= b4[win];
                    alu_s_q  <= s4[win];
                    rsp_id_q <= win;
                    cnt_q    <= 4'(EXEC_CYCLES);
                    ptr_q    <= (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_r_q     <= alu_r;
                        rsp_c_q     <= alu_c;
                        rsp_v_q     <= alu_v;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign busy      = state_q != IDLE;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit `alu` instance (operands a/b, select s; results r, c, v) between NREQ requesters.
- Round-robin arbitration picks one requester. The block registers that requester's operands onto the ALU inputs and waits a fixed settle time. It then captures the result and returns it through a valid/ready response port tagged with the requester ID.
- Sits between switch/button front-ends (or future sequencers) and the ALU, replacing direct operand wiring.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- W, 8, operand/result width; matches the ALU.
- SW, 4, ALU select width.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- CLK100MHZ  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid, bit i = requester i.
- req_a  in  NREQ*W  operand a; requester i on [i*W +: W].
- req_b  in  NREQ*W  operand b; same slicing.
- req_s  in  NREQ*SW  ALU select; requester i on [i*SW +: SW].
- req_ready  out  NREQ  one-hot grant/accept.
- alu_a  out  W  registered operand a to ALU.
- alu_b  out  W  registered operand b to ALU.
- alu_s  out  SW  registered select to ALU.
- alu_r  in  W  ALU result.
- alu_c  in  1  ALU carry.
- alu_v  in  1  ALU overflow.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  2  index of the requester that owns the response.
- rsp_r  out  W  captured result.
- rsp_c  out  1  captured carry.
- rsp_v  out  1  captured overflow.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset.** rst is asynchronous and active-high. While asserted:
  - state=IDLE, priority pointer ptr=0, cycle counter=0.
  - alu_a/alu_b/alu_s=0.
  - rsp_valid=0, rsp_id=0, rsp_r=0, rsp_c=0, rsp_v=0, busy=0.
  - req_ready=0 during reset.
  - Reset mid-operation aborts the transaction with no response; the requester must re-issue.
- **State IDLE.**
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready is combinational: one-hot on the winner, all zero if no request. Only in IDLE; req_ready=0 in every other state.
  - Transfer happens when req_valid[i] & req_ready[i]. On that edge:
    - alu_a/b/s load the winner's slices; rsp_id loads i.
    - counter loads EXEC_CYCLES; ptr <= (i+1) mod NREQ; state -> EXEC.
- **State EXEC.**
  - alu_a/b/s are held constant; counter decrements each cycle.
  - On the edge where counter==1: rsp_r/c/v <= alu_r/c/v; rsp_valid <= 1; state -> RESP.
- **State RESP.**
  - rsp_valid=1; rsp_id/r/c/v are held stable.
  - On the edge with rsp_ready=1: rsp_valid <= 0; state -> IDLE.
  - No new request is accepted on that edge.
- **Latency and throughput.**
  - Accept edge T; rsp_valid high from edge T+EXEC_CYCLES.
  - Minimum spacing between accepts is EXEC_CYCLES+2 cycles.
- **Request handshake rules.**
  - Requesters hold valid and payload stable until accepted.
  - Deasserting valid before acceptance is legal and has no effect.
  - A payload change while valid and not yet accepted is sampled as presented at the accept edge.
- **ALU operand hold.** alu_a/b/s keep the last accepted operands in IDLE and RESP; they are not cleared after a transaction.
- **Arbitration fairness.** With all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 transactions.
- **Stall.** A stalled rsp_ready holds RESP indefinitely. The result must not change even if alu_r changes.
- **rsp_id width.** Fixed 2 bits; upper bits are zero when NREQ<4.

Test Plan:
Bench uses a stub ALU: r=a+b (mod 256), c=carry out, v=signed overflow; s is ignored by the stub but must appear on alu_s.
1. **Reset mid-op.** Accept req0 a=8'h10,b=8'h20, then pulse rst during EXEC -> all outputs 0, no rsp_valid; then req1 a=8'h01,b=8'h02 -> rsp_id=1, rsp_r=8'h03.
2. **Single request.** req0 a=8'h7F,b=8'h01,s=4'h3, EXEC_CYCLES=1, rsp_ready=1 -> alu_s=4'h3; rsp_valid exactly 1 cycle after accept; rsp_r=8'h80, c=0, v=1, rsp_id=0.
3. **Carry case.** req1 a=8'hFF,b=8'h01 -> rsp_r=8'h00, c=1, v=0, rsp_id=1.
4. **Round-robin.** All NREQ=2 requesters held valid for 4 transactions -> rsp_id sequence 0,1,0,1; req_ready never has two bits set.
5. **Response stall.** rsp_ready=0 for 10 cycles after rsp_valid, while bench changes alu_r and req1 stays valid -> rsp_r/c/v/id stable; req_ready=0; busy=1; req1 accepted only after rsp_ready.
6. **Settle time.** EXEC_CYCLES=4, accept at cycle T -> alu_a/b/s constant T..T+4; rsp_valid first high at T+4; a valid request withdrawn before grant is never accepted.
